// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// ALU/PC source selects and the control-word payload.
package multicycle_control_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the controller state to its datapath control word.
module mc_ctrl_decode
  import multicycle_control_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl           = '0;
    ctrl.alu_src_b = SRCB_REG;
    ctrl.alu_op    = ALU_OP_ADD;
    ctrl.pc_source = PC_SRC_ALU;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and output gating.
// Optional memory-wait stalls in FETCH/MEMRD/MEMWR are enabled by MC_CTRL_STALL_EN.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               mem_to_reg_o,
  output logic               reg_dst_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic [1:0]         pc_source_o,
  output logic [STATE_W-1:0] state_o,
  output logic               illegal_o
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;
  logic   hold;

`ifdef MC_CTRL_STALL_EN
  assign hold = !mem_ready_i &&
                (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR);
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready_i;
  assign hold             = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    if (hold) state_d = state_q;
  end

  mc_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl_raw)
  );

  // A held fetch keeps the memory read up but must not advance PC or IR.
  always_comb begin
    ctrl = ctrl_raw;
    if (hold && state_q == S_FETCH) begin
      ctrl.pc_write = 1'b0;
      ctrl.ir_write = 1'b0;
    end
    if (rst_i) ctrl = '0;
  end

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign i_or_d_o        = ctrl.i_or_d;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign ir_write_o      = ctrl.ir_write;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_dst_o       = ctrl.reg_dst;
  assign reg_write_o     = ctrl.reg_write;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign alu_op_o        = ctrl.alu_op;
  assign pc_source_o     = ctrl.pc_source;
  assign state_o         = STATE_W'(state_q);
  assign illegal_o       = !rst_i && (state_q == S_DECODE) && !op_supported(Op_i);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-plan reference model checked every
// cycle, plus directed instruction sequences with literal state expectations.
module tb_multicycle_control;

`ifdef MC_CTRL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  logic       clk;
  logic       rst_i;
  logic [5:0] Op_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_source_o;
  logic [3:0] state_o;
  logic       illegal_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  multicycle_control dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .Op_i           (Op_i),
    .mem_ready_i    (mem_ready_i),
    .pc_write_o     (pc_write_o),
    .pc_write_cond_o(pc_write_cond_o),
    .i_or_d_o       (i_or_d_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .ir_write_o     (ir_write_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .reg_dst_o      (reg_dst_o),
    .reg_write_o    (reg_write_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .pc_source_o    (pc_source_o),
    .state_o        (state_o),
    .illegal_o      (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each instruction is FETCH, DECODE, then a per-opcode plan.
  int m_state = 0;
  int plan[$];

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b001000 || op == 6'b100011 ||
           op == 6'b101011 || op == 6'b000100 || op == 6'b000010;
  endfunction

  function automatic void fill_plan(input logic [5:0] op);
    plan.delete();
    case (op)
      6'b100011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      6'b101011: begin plan.push_back(2); plan.push_back(5); end
      6'b000000: begin plan.push_back(6); plan.push_back(7); end
      6'b001000: begin plan.push_back(9); plan.push_back(10); end
      6'b000100: plan.push_back(8);
      6'b000010: plan.push_back(11);
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      m_state = 0;
      plan.delete();
    end else if (STALL && !mem_ready_i && (m_state == 0 || m_state == 3 || m_state == 5)) begin
      m_state = m_state;
    end else if (m_state == 0) begin
      m_state = 1;
    end else begin
      if (m_state == 1) fill_plan(Op_i);
      if (plan.size() > 0) m_state = plan.pop_front();
      else                 m_state = 0;
    end
  end

  function automatic ctl_t expect_ctl(input int st, input logic [5:0] op,
                                      input logic rst, input logic mr);
    ctl_t e;
    e = '0;
    case (st)
      0:  begin e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; end
      1:  e.alu_src_b = 2'b11;
      2, 9: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.i_or_d = 1; e.mem_read = 1; end
      4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
      5:  begin e.i_or_d = 1; e.mem_write = 1; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_dst = 1; e.reg_write = 1; end
      10: e.reg_write = 1;
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; e.pc_write_cond = 1; end
      11: begin e.pc_source = 2'b10; e.pc_write = 1; end
      default: ;
    endcase
    e.illegal = (st == 1) && !is_legal(op);
    if (STALL && st == 0 && !mr) begin
      e.pc_write = 0;
      e.ir_write = 0;
    end
    if (rst) e = '0;
    return e;
  endfunction

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      ctl_t e;
      ctl_t a;
      e = expect_ctl(m_state, Op_i, rst_i, mem_ready_i);
      a = {pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
           mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           pc_source_o, illegal_o};
      n_cmp++;
      if (state_o !== 4'(m_state)) begin
        n_err++;
        $display("FAIL model_state t=%0t: got %0d expected %0d", $time, state_o, m_state);
      end
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL model_ctl t=%0t state=%0d: got %05h expected %05h", $time, m_state, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Runs one instruction from FETCH; seq holds the expected states, one nibble each.
  task automatic run(input logic [5:0] op, input logic [31:0] seq, input int n);
    Op_i = op;
    for (int i = 0; i < n; i++) begin
      logic [3:0] es;
      es = seq[4*i +: 4];
      @(negedge clk);
      chk("seq_state", 32'(state_o), 32'(es));
      chk("seq_reg_write", 32'(reg_write_o), 32'(es == 4'd4 || es == 4'd7 || es == 4'd10));
      chk("seq_illegal", 32'(illegal_o), 32'(es == 4'd1 && op == 6'b111111));
      if (es == 4'd4) chk("lw_mem_to_reg", 32'(mem_to_reg_o), 32'd1);
      if (es == 4'd8) begin
        chk("beq_pc_write_cond", 32'(pc_write_cond_o), 32'd1);
        chk("beq_pc_source", 32'(pc_source_o), 32'd1);
        chk("beq_alu_op", 32'(alu_op_o), 32'd1);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    Op_i        = 6'b000000;
    mem_ready_i = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pc_write", 32'(pc_write_o), 32'd0);
    chk("rst_mem_read", 32'(mem_read_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    run(6'b100011, 32'h43210, 5);
    run(6'b000100, 32'h810, 3);
    run(6'b111111, 32'h10, 2);
    run(6'b000000, 32'h10, 2);
    rst_i = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'(state_o), 32'd6);
    chk("abort_reg_write", 32'(reg_write_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    run(6'b101011, 32'h5210, 4);
    run(6'b001000, 32'hA910, 4);
    run(6'b000010, 32'hB10, 3);

`ifdef MC_CTRL_STALL_EN
    Op_i        = 6'b101011;
    mem_ready_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("fstall_state", 32'(state_o), 32'd0);
      chk("fstall_pc_write", 32'(pc_write_o), 32'd0);
      chk("fstall_ir_write", 32'(ir_write_o), 32'd0);
      chk("fstall_mem_read", 32'(mem_read_o), 32'd1);
      @(posedge clk); #1;
    end
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("fready_pc_write", 32'(pc_write_o), 32'd1);
    chk("fready_ir_write", 32'(ir_write_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fstall_next", 32'(state_o), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wstall_state", 32'(state_o), 32'd5);
      chk("wstall_mem_write", 32'(mem_write_o), 32'd1);
      @(posedge clk); #1;
    end
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("wready_state", 32'(state_o), 32'd5);
    chk("wready_mem_write", 32'(mem_write_o), 32'd1);
    @(posedge clk); #1;
`endif

    // Random instruction mix, random memory waits and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if (m_state == 0) begin
        int unsigned k;
        k = $urandom_range(0, 7);
        case (k)
          0: Op_i = 6'b000000;
          1: Op_i = 6'b001000;
          2: Op_i = 6'b100011;
          3: Op_i = 6'b101011;
          4: Op_i = 6'b000100;
          5: Op_i = 6'b000010;
          default: Op_i = 6'($urandom_range(0, 63));
        endcase
      end
      mem_ready_i = ($urandom_range(0, 3) != 0);
      rst_i       = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    rst_i = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
